// File: rtl/rst_pkg.sv
// Shared types and defaults for the staged reset release controller.
// Holds the sequencer state encoding and the counter width helper.
`timescale 1ns/100ps
package rst_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT    = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_DONE      = 2'd3
    } seq_state_t;

    localparam int DEF_NUM_STAGES = 4;
    localparam int DEF_STAGE_DLY  = 16;
    localparam int DEF_MIN_ASSERT = 8;

    // Counter must hold the larger of the two delay terminal counts.
    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Lock/request inputs and staged reset outputs of the reset sequencer.
// The slave side is the sequencer; the master side is the surrounding logic.
`timescale 1ns/100ps
interface reset_sequencer_if
    import rst_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES
) ();

    logic                  pll_lock;
    logic                  soft_rst_req;
    logic [NUM_STAGES-1:0] rst_n_out;
    logic                  seq_done;

    modport master (
        output pll_lock,
        output soft_rst_req,
        input  rst_n_out,
        input  seq_done
    );

    modport slave (
        input  pll_lock,
        input  soft_rst_req,
        output rst_n_out,
        output seq_done
    );

endinterface

// File: rtl/reset_sequencer_sync.sv
// Synchronizers feeding the sequencer: reset release (async assert,
// sync deassert) and a plain two-flop data synchronizer for PLL lock.
`timescale 1ns/100ps
module reset_sync (
    input  logic clk,
    input  logic arst_n,
    output logic rst_sync_n
);

    logic meta_r;
    logic sync_r;

    // Two-stage release shift; any assertion clears both stages at once.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= 1'b1;
            sync_r <= meta_r;
        end
    end

    assign rst_sync_n = sync_r;

endmodule

module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic sync_r;

    // Double-flop capture of an input asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: holds all block resets for a minimum width, waits
// for PLL lock, then releases them one by one; lock loss or soft request restarts.
`timescale 1ns/100ps
module reset_sequencer
    import rst_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int STAGE_DLY  = DEF_STAGE_DLY,
    parameter int MIN_ASSERT = DEF_MIN_ASSERT
) (
    input  logic              clk,
    input  logic              asyncrst_n,
    reset_sequencer_if.slave  bus
);

    localparam int CW = cnt_width(STAGE_DLY, MIN_ASSERT);
    localparam int KW = $clog2(NUM_STAGES) + 1;

    localparam logic [CW-1:0]         CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0]         CNT_ONE    = CW'(1'b1);
    localparam logic [CW-1:0]         MIN_LAST   = CW'(MIN_ASSERT - 1);
    localparam logic [CW-1:0]         STAGE_LAST = CW'(STAGE_DLY - 1);
    localparam logic [KW-1:0]         K_ZERO     = {KW{1'b0}};
    localparam logic [KW-1:0]         K_ONE      = KW'(1'b1);
    localparam logic [KW-1:0]         K_LAST     = KW'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] OUT_ZERO   = {NUM_STAGES{1'b0}};
    localparam logic [NUM_STAGES-1:0] OUT_ALL    = {NUM_STAGES{1'b1}};
    localparam logic [NUM_STAGES-1:0] OUT_ONE    = NUM_STAGES'(1'b1);

    logic                  rst_sync_n;
    logic                  lock_s;
    seq_state_t            state_r;
    seq_state_t            state_nxt_s;
    logic [CW-1:0]         cnt_r;
    logic [CW-1:0]         cnt_nxt_s;
    logic [KW-1:0]         stage_r;
    logic [KW-1:0]         stage_nxt_s;
    logic [NUM_STAGES-1:0] rst_n_out_r;
    logic [NUM_STAGES-1:0] rst_n_out_nxt_s;
    logic                  seq_done_r;
    logic                  seq_done_nxt_s;

    reset_sync u_reset_sync (
        .clk        (clk),
        .arst_n     (asyncrst_n),
        .rst_sync_n (rst_sync_n)
    );

    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (asyncrst_n),
        .d     (bus.pll_lock),
        .q     (lock_s)
    );

    // Sequencer state register.
    always_ff @(posedge clk or negedge asyncrst_n) begin
        if (!asyncrst_n) begin
            state_r <= ST_ASSERT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state, counters and output values; abort beats a stage release.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        stage_nxt_s     = stage_r;
        rst_n_out_nxt_s = rst_n_out_r;
        seq_done_nxt_s  = seq_done_r;
        case (state_r)
            ST_ASSERT: begin
                rst_n_out_nxt_s = OUT_ZERO;
                seq_done_nxt_s  = 1'b0;
                stage_nxt_s     = K_ZERO;
                if (!rst_sync_n || bus.soft_rst_req) begin
                    cnt_nxt_s = CNT_ZERO;
                end else if (cnt_r == MIN_LAST) begin
                    state_nxt_s = ST_WAIT_LOCK;
                    cnt_nxt_s   = CNT_ZERO;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_WAIT_LOCK: begin
                rst_n_out_nxt_s = OUT_ZERO;
                seq_done_nxt_s  = 1'b0;
                cnt_nxt_s       = CNT_ZERO;
                stage_nxt_s     = K_ZERO;
                if (bus.soft_rst_req) begin
                    state_nxt_s = ST_ASSERT;
                end else if (lock_s) begin
                    state_nxt_s = ST_RELEASE;
                end else begin
                    state_nxt_s = ST_WAIT_LOCK;
                end
            end
            ST_RELEASE: begin
                if (bus.soft_rst_req || !lock_s) begin
                    state_nxt_s     = ST_ASSERT;
                    cnt_nxt_s       = CNT_ZERO;
                    stage_nxt_s     = K_ZERO;
                    rst_n_out_nxt_s = OUT_ZERO;
                    seq_done_nxt_s  = 1'b0;
                end else if (cnt_r == STAGE_LAST) begin
                    rst_n_out_nxt_s = rst_n_out_r | (OUT_ONE << stage_r);
                    cnt_nxt_s       = CNT_ZERO;
                    stage_nxt_s     = stage_r + K_ONE;
                    if (stage_r == K_LAST) begin
                        state_nxt_s    = ST_DONE;
                        seq_done_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_RELEASE;
                    end
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_DONE: begin
                if (bus.soft_rst_req || !lock_s) begin
                    state_nxt_s     = ST_ASSERT;
                    cnt_nxt_s       = CNT_ZERO;
                    stage_nxt_s     = K_ZERO;
                    rst_n_out_nxt_s = OUT_ZERO;
                    seq_done_nxt_s  = 1'b0;
                end else begin
                    rst_n_out_nxt_s = OUT_ALL;
                    seq_done_nxt_s  = 1'b1;
                end
            end
            default: begin
                state_nxt_s     = ST_ASSERT;
                cnt_nxt_s       = CNT_ZERO;
                stage_nxt_s     = K_ZERO;
                rst_n_out_nxt_s = OUT_ZERO;
                seq_done_nxt_s  = 1'b0;
            end
        endcase
    end

    // Counters and output flops; outputs leave the block straight from here.
    always_ff @(posedge clk or negedge asyncrst_n) begin
        if (!asyncrst_n) begin
            cnt_r       <= CNT_ZERO;
            stage_r     <= K_ZERO;
            rst_n_out_r <= OUT_ZERO;
            seq_done_r  <= 1'b0;
        end else begin
            cnt_r       <= cnt_nxt_s;
            stage_r     <= stage_nxt_s;
            rst_n_out_r <= rst_n_out_nxt_s;
            seq_done_r  <= seq_done_nxt_s;
        end
    end

    assign bus.rst_n_out = rst_n_out_r;
    assign bus.seq_done  = seq_done_r;

endmodule
